// File: rtl/fixed_point_pkg.sv
// fixed_point_pkg: shared width default, FSM state encoding and signed range helpers
package fixed_point_pkg;
  localparam int FP_N = 16;
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} acc_state_e;
  function automatic logic [63:0] max_pos(input int n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction
  function automatic logic [63:0] min_neg(input int n);
    return 64'd1 << (n - 1);
  endfunction
endpackage

// File: rtl/fixed_point_accumulator_if.sv
// fixed_point_accumulator_if: operand stream in, result stream out
interface fixed_point_accumulator_if
  import fixed_point_pkg::*;
#(
  parameter int N = FP_N,
  parameter int CNT_W = 8
);
  logic in_valid;
  logic in_ready;
  logic [N-1:0] in_data;
  logic in_sub;
  logic in_last;
  logic out_valid;
  logic out_ready;
  logic [N-1:0] out_data;
  logic out_overflow;
  logic [CNT_W-1:0] out_count;
  modport master (
    output in_valid, in_data, in_sub, in_last, out_ready,
    input in_ready, out_valid, out_data, out_overflow, out_count
  );
  modport slave (
    input in_valid, in_data, in_sub, in_last, out_ready,
    output in_ready, out_valid, out_data, out_overflow, out_count
  );
endinterface

// File: rtl/adder.sv
// adder: combinational two's complement add/subtract with overflow and true sign
module adder #(
  parameter int N = 16
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         is_subtract,
  output logic [N-1:0] result,
  output logic         overflow_flag,
  output logic         negative,
  output logic         carry
);
  logic [N:0] wide;
  logic [N:0] uns;
  // One extra sign bit keeps the infinite-precision sign of the sum
  assign wide = is_subtract ? {A[N-1], A} - {B[N-1], B} : {A[N-1], A} + {B[N-1], B};
  assign uns = {1'b0, A} + {1'b0, is_subtract ? ~B : B} + {{N{1'b0}}, is_subtract};
  assign result = wide[N-1:0];
  assign overflow_flag = wide[N] ^ wide[N-1];
  assign negative = wide[N];
  assign carry = uns[N];
endmodule

// File: rtl/sat_clamp.sv
// sat_clamp: overflow handling for the accumulator; ACC_SATURATE_EN selects clamp, else wrap
module sat_clamp
  import fixed_point_pkg::*;
#(
  parameter int N = FP_N
) (
  input  logic [N-1:0] result,
  input  logic         overflow_flag,
  input  logic         negative,
  output logic [N-1:0] next_acc
);
`ifdef ACC_SATURATE_EN
  localparam logic [N-1:0] MAX_POS = N'(max_pos(N));
  localparam logic [N-1:0] MIN_NEG = N'(min_neg(N));
  always_comb next_acc = overflow_flag ? (negative ? MIN_NEG : MAX_POS) : result;
`else
  logic unused_flags;
  assign unused_flags = overflow_flag ^ negative;
  always_comb next_acc = result;
`endif
endmodule

// File: rtl/fixed_point_accumulator.sv
// fixed_point_accumulator: framed running sum with sticky overflow and beat count.
// ACC_SATURATE_EN clamps the sum on overflow; otherwise it wraps.
module fixed_point_accumulator
  import fixed_point_pkg::*;
#(
  parameter int N = FP_N,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst_n,
  input logic clear,
  fixed_point_accumulator_if.slave bus
);
  acc_state_e state_q, state_d;
  logic [N-1:0] acc_q, acc_d, out_data_q, out_data_d, sum, next_acc;
  logic [CNT_W-1:0] count_q, count_d, out_count_q, out_count_d, count_inc;
  logic ovf_q, ovf_d, out_ovf_q, out_ovf_d, add_ovf, add_neg, adder_carry_unused;
  logic beat, last_beat, done, flush;
  adder #(.N(N)) u_adder (
    .A(acc_q),
    .B(bus.in_data),
    .is_subtract(bus.in_sub),
    .result(sum),
    .overflow_flag(add_ovf),
    .negative(add_neg),
    .carry(adder_carry_unused)
  );
  sat_clamp #(.N(N)) u_clamp (
    .result(sum),
    .overflow_flag(add_ovf),
    .negative(add_neg),
    .next_acc(next_acc)
  );
  assign beat = bus.in_valid && bus.in_ready;
  assign last_beat = beat && bus.in_last;
  assign done = bus.out_valid && bus.out_ready;
  // Leaving HOLD and clear both return the frame state to zero
  assign flush = clear || done;
  assign count_inc = &count_q ? count_q : count_q + 1'b1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q <= '0;
      count_q <= '0;
      ovf_q <= 1'b0;
      out_data_q <= '0;
      out_count_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      count_q <= count_d;
      ovf_q <= ovf_d;
      out_data_q <= out_data_d;
      out_count_q <= out_count_d;
      out_ovf_q <= out_ovf_d;
    end
  end
  always_comb begin
    state_d = clear ? IDLE
            : state_q == HOLD ? (done ? IDLE : HOLD)
            : beat ? (bus.in_last ? HOLD : ACCUM)
            : state_q;
  end
  always_comb begin
    acc_d = flush ? '0 : beat ? next_acc : acc_q;
    count_d = flush ? '0 : beat ? count_inc : count_q;
    ovf_d = flush ? 1'b0 : beat ? (ovf_q | add_ovf) : ovf_q;
    out_data_d = flush ? '0 : last_beat ? next_acc : out_data_q;
    out_count_d = flush ? '0 : last_beat ? count_inc : out_count_q;
    out_ovf_d = flush ? 1'b0 : last_beat ? (ovf_q | add_ovf) : out_ovf_q;
  end
  always_comb begin
    bus.in_ready = state_q != HOLD;
    bus.out_valid = state_q == HOLD;
    bus.out_data = out_data_q;
    bus.out_count = out_count_q;
    bus.out_overflow = out_ovf_q;
  end
endmodule
